// File: rtl/delay_sub_pipe.sv
// Multi-channel delay line with a registered per-channel subtract and borrow/underflow monitoring.
// Optional: define DELAY_SUB_PIPE_SATURATE_EN to clamp borrowed channels to zero instead of wrapping.

module delay_sub_lane #(
  parameter int DATA_W = 32,
  parameter int DELAY  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] sub_in,
  input  logic              sub_load,
  input  logic              out_ld,
  output logic              borrow,
  output logic [DATA_W-1:0] res,
  output logic              uf
);
  logic [DELAY-1:0][DATA_W-1:0] dly;
  logic [DATA_W-1:0]            sub_reg;
  logic [DATA_W-1:0]            diff;

  assign {borrow, diff} = {1'b0, dly[DELAY-1]} - {1'b0, sub_reg};

  // data stages carry no reset; sample validity lives in the top-level vld_pipe
  always_ff @(posedge clk) begin
    dly[0] <= din;
    for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_reg <= '0;
      res     <= '0;
      uf      <= 1'b0;
    end else begin
      if (sub_load) sub_reg <= sub_in;
      if (out_ld) begin
`ifdef DELAY_SUB_PIPE_SATURATE_EN
        res <= borrow ? '0 : diff;
`else
        res <= diff;
`endif
        uf  <= borrow;
      end else begin
        res <= '0;
        uf  <= 1'b0;
      end
    end
  end
endmodule

module delay_sub_pipe #(
  parameter int DATA_W   = 32,
  parameter int N_CH     = 4,
  parameter int DELAY    = 5,
  parameter int UF_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic                   data_in_valid,
  input  logic [N_CH*DATA_W-1:0] sub_in,
  input  logic                   sub_load,
  input  logic                   flush,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic                   data_out_valid,
  output logic [N_CH-1:0]        underflow,
  output logic [UF_CNT_W-1:0]    uf_count
);
  localparam logic [UF_CNT_W-1:0] UF_MAX = '1;

  logic [N_CH-1:0][DATA_W-1:0] din_a, sub_a, res_a;
  logic [N_CH-1:0]             borrow;
  // [0..DELAY-1] delay stages, [DELAY] registered output stage
  logic [DELAY:0]              vld_pipe;
  logic                        out_ld;

  assign din_a          = data_in;
  assign sub_a          = sub_in;
  assign data_out       = res_a;
  assign data_out_valid = vld_pipe[DELAY];
  // flush kills whatever sits in the last stage, so nothing is computed for it
  assign out_ld         = vld_pipe[DELAY-1] & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= data_in_valid;
      for (int i = 1; i <= DELAY; i++) vld_pipe[i] <= vld_pipe[i-1] & ~flush;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                        uf_count <= '0;
    else if (out_ld && (|borrow) && uf_count != UF_MAX) uf_count <= uf_count + 1'b1;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    delay_sub_lane #(.DATA_W(DATA_W), .DELAY(DELAY)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .din      (din_a[c]),
      .sub_in   (sub_a[c]),
      .sub_load (sub_load),
      .out_ld   (out_ld),
      .borrow   (borrow[c]),
      .res      (res_a[c]),
      .uf       (underflow[c])
    );
  end
endmodule

// File: tb/tb_delay_sub_pipe.sv
// Bench for delay_sub_pipe: directed table vectors, multi-cycle sequences, and a random run
// against a cycle-history reference model; a second small instance covers DELAY=1 and counter saturation.

module tb_delay_sub_pipe;
  localparam int DW = 32, NC = 4, DL = 5, NR = 600;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  data_in, sub_in, data_out;
  logic          data_in_valid, sub_load, flush, data_out_valid;
  logic [3:0]    underflow;
  logic [15:0]   uf_count;

  logic [7:0]    b_din, b_sub, b_dout;
  logic          b_v, b_ld, b_fl, b_vo;
  logic [0:0]    b_uf;
  logic [1:0]    b_cnt;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  delay_sub_pipe #(.DATA_W(DW), .N_CH(NC), .DELAY(DL), .UF_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .sub_in(sub_in), .sub_load(sub_load), .flush(flush), .data_out(data_out),
    .data_out_valid(data_out_valid), .underflow(underflow), .uf_count(uf_count));

  delay_sub_pipe #(.DATA_W(8), .N_CH(1), .DELAY(1), .UF_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_v),
    .sub_in(b_sub), .sub_load(b_ld), .flush(b_fl), .data_out(b_dout),
    .data_out_valid(b_vo), .underflow(b_uf), .uf_count(b_cnt));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] satx(input logic [127:0] v, input logic [3:0] u);
`ifdef DELAY_SUB_PIPE_SATURATE_EN
    for (int c = 0; c < NC; c++) if (u[c]) v[c*DW +: DW] = '0;
`endif
    return v;
  endfunction

  typedef struct {
    logic [127:0] d;
    logic [31:0]  s;
    logic [127:0] exp;
    logic [3:0]   uf;
  } vec_t;

  vec_t         tbl[3];
  logic         h_rst[NR], h_fl[NR], h_v[NR], h_ld[NR];
  logic [127:0] h_d[NR], h_s[NR], sub_eff[NR+1];

  initial begin
    logic [15:0]  e_cnt, mcnt;
    logic [127:0] ed;
    logic [3:0]   eu;
    logic         ev;
    logic [31:0]  dv, sv;
    logic [1:0]   e_bc;
    int           a;

    tbl[0] = '{d: {32'd400, 32'd300, 32'd200, 32'd100}, s: 32'd10,
               exp: {32'd390, 32'd290, 32'd190, 32'd90}, uf: 4'b0000};
    tbl[1] = '{d: {32'd5, 32'd5, 32'd5, 32'd3}, s: 32'd5,
               exp: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE}, uf: 4'b0001};
    tbl[2] = '{d: {32'd8, 32'd7, 32'hFFFF_FFFF, 32'd0}, s: 32'd8,
               exp: {32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 32'hFFFF_FFF8}, uf: 4'b0101};

    rst = 1'b1; data_in = '0; sub_in = '0; data_in_valid = 0; sub_load = 0; flush = 0;
    b_din = '0; b_sub = '0; b_v = 0; b_ld = 0; b_fl = 0;

    // reset / idle
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b0;
      step();
      chk($sformatf("rst_dout%0d", i), data_out, '0);
      chk($sformatf("rst_vld%0d", i), data_out_valid, 0);
      chk($sformatf("rst_uf%0d", i), underflow, 0);
      chk($sformatf("rst_cnt%0d", i), uf_count, 0);
    end

    // table vectors: one sample each, exact latency DL+1
    e_cnt = 0;
    for (int t = 0; t < 3; t++) begin
      sub_in = {4{tbl[t].s}}; sub_load = 1; step(); sub_load = 0;
      data_in = tbl[t].d; data_in_valid = 1; step(); data_in_valid = 0; data_in = '0;
      for (int k = 1; k < DL; k++) step();
      chk($sformatf("tbl%0d_early", t), data_out_valid, 0);
      step();
      if (tbl[t].uf != 0) e_cnt++;
      chk($sformatf("tbl%0d_vld", t), data_out_valid, 1);
      chk($sformatf("tbl%0d_data", t), data_out, satx(tbl[t].exp, tbl[t].uf));
      chk($sformatf("tbl%0d_uf", t), underflow, tbl[t].uf);
      chk($sformatf("tbl%0d_cnt", t), uf_count, e_cnt);
      step();
      chk($sformatf("tbl%0d_once", t), data_out_valid, 0);
    end

    // streaming with sub_load 10->20 while in flight
    sub_in = {4{32'd10}}; sub_load = 1; step(); sub_load = 0;
    for (int k = 0; k < 16; k++) begin
      data_in = {4{32'd50}}; data_in_valid = (k < 8);
      sub_in = {4{32'd20}}; sub_load = (k == 7);
      step();
      a = k - DL;
      chk($sformatf("strm_vld%0d", k), data_out_valid, (a >= 0 && a < 8));
      if (a >= 0 && a < 8)
        chk($sformatf("strm_data%0d", k), data_out, (a < 3) ? {4{32'd40}} : {4{32'd30}});
    end
    data_in_valid = 0; sub_load = 0;

    // flush kills older samples, keeps the one accepted alongside it
    for (int k = 0; k < 12; k++) begin
      data_in = {4{32'((k + 1) * 11)}}; data_in_valid = (k < 4); flush = (k == 2);
      step();
      a = k - DL;
      chk($sformatf("fl_vld%0d", k), data_out_valid, (a == 2 || a == 3));
      if (a == 2 || a == 3)
        chk($sformatf("fl_data%0d", k), data_out, {4{32'((a + 1) * 11 - 20)}});
    end
    flush = 0; data_in_valid = 0;

    // random run against history model
    sub_eff[0] = '0; mcnt = 0;
    for (int k = 0; k < NR; k++) begin
      h_rst[k] = (k == 0) || ($urandom_range(0, 63) == 0);
      h_fl[k]  = ($urandom_range(0, 15) == 0);
      h_v[k]   = ($urandom_range(0, 3) != 0);
      h_ld[k]  = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < NC; c++) begin
        h_d[k][c*DW +: DW] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300);
        h_s[k][c*DW +: DW] = $urandom_range(0, 200);
      end
      rst = h_rst[k]; flush = h_fl[k]; data_in_valid = h_v[k]; sub_load = h_ld[k];
      data_in = h_d[k]; sub_in = h_s[k];
      sub_eff[k+1] = h_rst[k] ? '0 : (h_ld[k] ? h_s[k] : sub_eff[k]);
      step();
      a = k - DL; ev = 0; ed = '0; eu = '0;
      if (a >= 0 && h_v[a]) begin
        ev = 1;
        for (int j = a; j <= k; j++) if (h_rst[j] || (j > a && h_fl[j])) ev = 0;
      end
      if (ev) begin
        for (int c = 0; c < NC; c++) begin
          dv = h_d[a][c*DW +: DW]; sv = sub_eff[k][c*DW +: DW];
          eu[c] = dv < sv;
          ed[c*DW +: DW] = dv - sv;
        end
        ed = satx(ed, eu);
      end
      if (h_rst[k]) mcnt = 0;
      else if (ev && eu != 0 && mcnt != 16'hFFFF) mcnt++;
      chk($sformatf("rnd_vld%0d", k), data_out_valid, ev);
      chk($sformatf("rnd_data%0d", k), data_out, ed);
      chk($sformatf("rnd_uf%0d", k), underflow, eu);
      chk($sformatf("rnd_cnt%0d", k), uf_count, mcnt);
    end
    rst = 0; flush = 0; data_in_valid = 0; sub_load = 0;

    // DELAY=1, N_CH=1, 2-bit saturating counter
    rst = 1; step(); rst = 0;
    chk("b_cnt_rst", b_cnt, 0);
    b_sub = 8'd5; b_ld = 1; step(); b_ld = 0;
    e_bc = 0;
    for (int k = 0; k < 7; k++) begin
      b_din = 8'd1; b_v = (k < 5);
      step();
      a = k - 1;
      if (a >= 0 && a < 5 && e_bc != 2'd3) e_bc++;
      chk($sformatf("b_vld%0d", k), b_vo, (a >= 0 && a < 5));
`ifdef DELAY_SUB_PIPE_SATURATE_EN
      chk($sformatf("b_data%0d", k), b_dout, 8'h00);
`else
      chk($sformatf("b_data%0d", k), b_dout, (a >= 0 && a < 5) ? 8'hFC : 8'h00);
`endif
      chk($sformatf("b_uf%0d", k), b_uf, (a >= 0 && a < 5));
      chk($sformatf("b_cnt%0d", k), b_cnt, e_bc);
    end
    b_v = 0;
    rst = 1; step(); rst = 0;
    chk("b_cnt_clr", b_cnt, 0);
    chk("b_vld_clr", b_vo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
